// File: rtl/present_core_debug_pkg.sv
// Shared types and constants for the PRESENT core debug OCI memory path:
// controller FSM states, default sizing and the jdo field layout.
package present_core_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ocimem_state_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TIMEOUT = 255;

  localparam int JDO_W           = 38;
  localparam int JDO_RD_BIT      = 35;
  localparam int JDO_WDATA_HI    = 34;
  localparam int JDO_WDATA_LO    = 3;
  localparam int JDO_ADDR_HI     = 33;
  localparam int JDO_ADDR_LO     = 26;
  localparam int JDO_CLR_ERR_BIT = 25;

endpackage

// File: rtl/present_core_debug_ocimem_timer.sv
// Per-access stall counter; expired flags the stalled cycle that brings the
// count to TIMEOUT, so the access is abandoned on that same edge.
module present_core_debug_ocimem_timer
  import present_core_debug_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/present_core_debug_ocimem_ctrl.sv
// Debug OCI memory controller: turns JTAG take_* commands into single
// read/write accesses on a waitrequest-style memory port.
module present_core_debug_ocimem_ctrl
  import present_core_debug_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_t state, state_n;
  logic [ADDR_W-1:0] mon_a_reg;
  logic busy;
  logic any_take;
  logic tmr_expired;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LO-1:0]};

  assign busy      = (state != IDLE);
  assign any_take  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign mem_addr  = mon_a_reg;
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);

  present_core_debug_ocimem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!busy),
    .en      (busy && mem_waitrequest),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo[JDO_RD_BIT]) state_n = RD;
        end else if (take_action_ocimem_b) begin
          state_n = WR;
        end else if (take_no_action_ocimem_a && monitor_ready) begin
          state_n = RD;
        end
      end
      RD, WR: begin
        if (!mem_waitrequest || tmr_expired) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command capture in IDLE; completion, timeout and collision while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      mem_wdata     <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (!busy) begin
      if (take_action_ocimem_a) begin
        mon_a_reg     <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
        monitor_ready <= 1'b0;
        if (jdo[JDO_CLR_ERR_BIT]) monitor_error <= 1'b0;
      end else if (take_action_ocimem_b) begin
        mem_wdata     <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
        monitor_ready <= 1'b0;
      end else if (take_no_action_ocimem_a && monitor_ready) begin
        mon_a_reg     <= mon_a_reg + 1'b1;
        monitor_ready <= 1'b0;
      end
    end else begin
      if (any_take) monitor_error <= 1'b1;
      if (!mem_waitrequest) begin
        if (state == RD) begin
          MonDReg <= mem_rdata;
        end else begin
          mon_a_reg <= mon_a_reg + 1'b1;
        end
        monitor_ready <= 1'b1;
      end else if (tmr_expired) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule
